mem_responder: RTL and testbench

Memory-side responder for the processor's memory-manager request interface. It receives `enable`/`rnw`/`addrMem`/`wordMem` requests, services them from an internal single-port RAM after a programmable number of wait states, and signals completion with `dataIsPresent`. It sits below `memman` on the memory bus and is the far end of that handshake.

---
 rtl/mem_responder_pkg.sv | 15 +
 rtl/mem_responder_ram.sv | 32 +++
 rtl/mem_responder.sv | 166 ++++++++++++++++
 tb/tb_mem_responder.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_responder_pkg.sv
// Shared definitions for the memory responder: FSM state encoding,
// default bus widths (common with memman) and the wait-counter width.
package mem_responder_pkg;

    localparam int unsigned DEF_ADDR_W = 8;
    localparam int unsigned DEF_DATA_W = 8;
    localparam int unsigned CNT_W      = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } state_t;

endpackage

// File: rtl/mem_responder_ram.sv
// Single-port RAM, DEPTH x DATA_W, with a synchronous write and a
// combinational read.
// Ports: clk, we (write enable), addr, wdata, rdata.
// The parent registers rdata on the access edge, so the combinational read
// lets read data land in the output register on the same edge as the write.
// Range checking of addresses is done by the parent.
module mem_responder_ram
    import mem_responder_pkg::*;
#(
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned AW     = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder for the memman request bus. Accepts a request,
// inserts WAIT_CYCLES wait states, performs the RAM access and completes a
// four-phase enable/dataIsPresent handshake.
// Ports:
//   clk, rst_n     clock, synchronous active-low reset
//   enable         request valid, held until completion
//   rnw            1 = read, 0 = write (latched on acceptance)
//   addrMem        word address (latched on acceptance)
//   wordMem        write data (latched on acceptance)
//   wordMemRd      read data, held until the next completed read
//   dataIsPresent  completion acknowledge
//   busy           high whenever the FSM is not idle
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int unsigned ADDR_W      = DEF_ADDR_W,
    parameter int unsigned DATA_W      = DEF_DATA_W,
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              rnw,
    input  logic [ADDR_W-1:0] addrMem,
    input  logic [DATA_W-1:0] wordMem,
    output logic [DATA_W-1:0] wordMemRd,
    output logic              dataIsPresent,
    output logic              busy
);

    localparam int unsigned RAM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CMP_W  = ADDR_W + 1;
    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_CYCLES);
    localparam bit ZERO_WAIT = (WAIT_CYCLES == 0);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                rnw_q, rnw_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rd_q, rd_d;
    logic                ack_q, ack_d;
    logic                busy_q, busy_d;

    logic                access;
    logic                acc_rnw;
    logic [ADDR_W-1:0]   acc_addr;
    logic [DATA_W-1:0]   acc_wdata;
    logic                in_range;
    logic                ram_we;
    logic [DATA_W-1:0]   ram_rdata;

    // Access operands: live inputs when accessing straight from IDLE
    // (zero wait states), otherwise the request latched at acceptance.
    always_comb begin
        acc_rnw   = rnw_q;
        acc_addr  = addr_q;
        acc_wdata = wdata_q;
        if (state_q == IDLE) begin
            acc_rnw   = rnw;
            acc_addr  = addrMem;
            acc_wdata = wordMem;
        end
        in_range = ({1'b0, acc_addr} < CMP_W'(DEPTH));
    end

    mem_responder_ram #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .AW     (RAM_AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (RAM_AW'(acc_addr)),
        .wdata (acc_wdata),
        .rdata (ram_rdata)
    );

    // Next-state, request latch, access decode and output next-values.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rnw_d   = rnw_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rd_d    = rd_q;
        access  = 1'b0;
        ram_we  = 1'b0;

        case (state_q)
            IDLE: begin
                if (enable) begin
                    rnw_d   = rnw;
                    addr_d  = addrMem;
                    wdata_d = wordMem;
                    if (ZERO_WAIT) begin
                        access  = 1'b1;
                        state_d = ACK;
                    end else begin
                        cnt_d   = WAIT_LOAD;
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (!enable) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(1)) begin
                    access  = 1'b1;
                    state_d = ACK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ACK: begin
                if (!enable) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // A reset on the access edge discards the write.
        ram_we = access && !acc_rnw && in_range && rst_n;
        if (access && acc_rnw) begin
            rd_d = in_range ? ram_rdata : '0;
        end

        ack_d  = (state_d == ACK);
        busy_d = (state_d != IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rnw_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rd_q    <= '0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rnw_q   <= rnw_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rd_q    <= rd_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
        end
    end

    assign wordMemRd     = rd_q;
    assign dataIsPresent = ack_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: a two-wait-state, 128-word instance
// (covers out-of-range addresses) and a zero-wait-state, 256-word instance.
module tb_mem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       en_a, rnw_a, dip_a, busy_a;
    logic [7:0] addr_a, wd_a, rd_a;
    logic       en_b, rnw_b, dip_b, busy_b;
    logic [7:0] addr_b, wd_b, rd_b;

    int total  = 0;
    int passed = 0;
    int failed = 0;

    mem_responder #(.ADDR_W(8), .DATA_W(8), .DEPTH(128), .WAIT_CYCLES(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .enable(en_a), .rnw(rnw_a), .addrMem(addr_a),
        .wordMem(wd_a), .wordMemRd(rd_a), .dataIsPresent(dip_a), .busy(busy_a)
    );

    mem_responder #(.ADDR_W(8), .DATA_W(8), .DEPTH(256), .WAIT_CYCLES(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .enable(en_b), .rnw(rnw_b), .addrMem(addr_b),
        .wordMem(wd_b), .wordMemRd(rd_b), .dataIsPresent(dip_b), .busy(busy_b)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit b, input logic e, input logic r,
                         input logic [7:0] a, input logic [7:0] d);
        if (!b) begin
            en_a = e; rnw_a = r; addr_a = a; wd_a = d;
        end else begin
            en_b = e; rnw_b = r; addr_b = a; wd_b = d;
        end
    endtask

    task automatic set_en(input bit b, input logic e);
        if (!b) en_a = e;
        else    en_b = e;
    endtask

    task automatic get(input bit b, output logic dp, output logic bz, output logic [7:0] rv);
        if (!b) begin
            dp = dip_a; bz = busy_a; rv = rd_a;
        end else begin
            dp = dip_b; bz = busy_b; rv = rd_b;
        end
    endtask

    // Counts edges until dataIsPresent rises; bounded at 20 edges.
    task automatic wait_ack(input bit b, input string tag, input int exp_lat);
        int         lat = 0;
        logic       dp, bz;
        logic [7:0] rv;
        get(b, dp, bz, rv);
        while (dp !== 1'b1 && lat < 20) begin
            step();
            lat++;
            get(b, dp, bz, rv);
        end
        check({tag, " latency"}, 8'(lat), 8'(exp_lat));
    endtask

    // Full handshake; returns wordMemRd as seen while acknowledged.
    task automatic xfer(input bit b, input logic r, input logic [7:0] a, input logic [7:0] d,
                        input string tag, output logic [7:0] rdv);
        logic dp, bz;
        drive(b, 1'b1, r, a, d);
        wait_ack(b, tag, b ? 1 : 3);
        get(b, dp, bz, rdv);
        set_en(b, 1'b0);
        step();
        get(b, dp, bz, d);
        check({tag, " dip drop"}, 8'(dp), 8'h00);
        check({tag, " busy drop"}, 8'(bz), 8'h00);
    endtask

    initial begin
        logic [7:0] rv;

        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        step();
        step();
        check("a rst dip", 8'(dip_a), 8'h00);
        check("a rst busy", 8'(busy_a), 8'h00);
        check("a rst rd", rd_a, 8'h00);
        check("b rst dip", 8'(dip_b), 8'h00);
        check("b rst busy", 8'(busy_b), 8'h00);
        check("b rst rd", rd_b, 8'h00);
        rst_n = 1'b1;
        step();

        // Write 0xA5 to 0x10 plus known preloads.
        xfer(1'b0, 1'b0, 8'h10, 8'hA5, "a wr10", rv);
        xfer(1'b0, 1'b0, 8'h11, 8'h00, "a pre11", rv);
        xfer(1'b0, 1'b0, 8'h21, 8'h5A, "a pre21", rv);
        xfer(1'b0, 1'b0, 8'h30, 8'h11, "a pre30", rv);

        // Read-back.
        xfer(1'b0, 1'b1, 8'h10, 8'h00, "a rd10", rv);
        check("a rd10 data", rv, 8'hA5);
        xfer(1'b0, 1'b1, 8'h11, 8'h00, "a rd11", rv);
        check("a rd11 data", rv, 8'h00);

        // Inputs changed after acceptance must be ignored.
        drive(1'b0, 1'b1, 1'b0, 8'h20, 8'h3C);
        step();
        check("a chg busy", 8'(busy_a), 8'h01);
        check("a chg dip", 8'(dip_a), 8'h00);
        drive(1'b0, 1'b1, 1'b0, 8'h21, 8'hFF);
        wait_ack(1'b0, "a chg", 2);
        set_en(1'b0, 1'b0);
        step();
        xfer(1'b0, 1'b1, 8'h20, 8'h00, "a rd20", rv);
        check("a rd20 data", rv, 8'h3C);
        xfer(1'b0, 1'b1, 8'h21, 8'h00, "a rd21", rv);
        check("a rd21 data", rv, 8'h5A);

        // Abort in the first wait cycle.
        drive(1'b0, 1'b1, 1'b0, 8'h30, 8'h77);
        step();
        check("a abort busy1", 8'(busy_a), 8'h01);
        set_en(1'b0, 1'b0);
        step();
        check("a abort busy0", 8'(busy_a), 8'h00);
        check("a abort dip", 8'(dip_a), 8'h00);
        step();
        check("a abort dip later", 8'(dip_a), 8'h00);
        xfer(1'b0, 1'b1, 8'h30, 8'h00, "a rd30", rv);
        check("a rd30 data", rv, 8'h11);

        // Out of range: write dropped (would alias 0x10), read returns 0,
        // and a write leaves wordMemRd alone.
        xfer(1'b0, 1'b1, 8'h10, 8'h00, "a rd10b", rv);
        xfer(1'b0, 1'b0, 8'h90, 8'hEE, "a wr90", rv);
        check("a wr keeps rd", rv, 8'hA5);
        xfer(1'b0, 1'b1, 8'h90, 8'h00, "a rd90", rv);
        check("a rd90 data", rv, 8'h00);
        xfer(1'b0, 1'b1, 8'h10, 8'h00, "a rd10c", rv);
        check("a rd10c data", rv, 8'hA5);

        // Zero-wait instance.
        xfer(1'b1, 1'b0, 8'h10, 8'hA5, "b wr10", rv);
        drive(1'b1, 1'b1, 1'b1, 8'h10, 8'h00);
        step();
        check("b rd10 dip", 8'(dip_b), 8'h01);
        check("b rd10 data", rd_b, 8'hA5);
        for (int i = 0; i < 5; i++) begin
            step();
            check("b hold dip", 8'(dip_b), 8'h01);
            check("b hold busy", 8'(busy_b), 8'h01);
        end
        set_en(1'b1, 1'b0);
        step();
        check("b rel dip", 8'(dip_b), 8'h00);
        // Held write with changing data: only the accepted word lands.
        drive(1'b1, 1'b1, 1'b0, 8'h40, 8'h42);
        step();
        check("b wr40 dip", 8'(dip_b), 8'h01);
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b1, 1'b0, 8'h40, 8'(i + 1));
            step();
            check("b hold wr dip", 8'(dip_b), 8'h01);
        end
        set_en(1'b1, 1'b0);
        step();
        xfer(1'b1, 1'b1, 8'h40, 8'h00, "b rd40", rv);
        check("b rd40 data", rv, 8'h42);

        // Reset on the would-be access edge discards the pending write.
        drive(1'b0, 1'b1, 1'b0, 8'h10, 8'h99);
        step();
        step();
        rst_n = 1'b0;
        step();
        check("a rst wait busy", 8'(busy_a), 8'h00);
        set_en(1'b0, 1'b0);
        rst_n = 1'b1;
        step();
        xfer(1'b0, 1'b1, 8'h10, 8'h00, "a rd10d", rv);
        check("a rd10d data", rv, 8'hA5);

        // Reset mid-ACK.
        drive(1'b0, 1'b1, 1'b1, 8'h21, 8'h00);
        wait_ack(1'b0, "a rd21b", 3);
        check("a rd21b data", rd_a, 8'h5A);
        rst_n = 1'b0;
        step();
        check("a rst ack dip", 8'(dip_a), 8'h00);
        check("a rst ack busy", 8'(busy_a), 8'h00);
        check("a rst ack rd", rd_a, 8'h00);
        set_en(1'b0, 1'b0);
        rst_n = 1'b1;
        step();
        xfer(1'b0, 1'b1, 8'h10, 8'h00, "a rd10e", rv);
        check("a rd10e data", rv, 8'hA5);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
